tri_raster: RTL and testbench
=============================

TRI_RASTER -- requirements
Module: tri_raster

Interface
REQ-001 Parameter W, default 12, unsigned coordinate width in bits (legal 4..16).
REQ-002 Parameter INCLUSIVE, default 1; 1 counts pixels on an edge as inside, 0 excludes them.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  triangle vertex set offered.
REQ-006 in_ready  output  1  block accepts a triangle this cycle.
REQ-007 p1x, p1y, p2x, p2y, p3x, p3y  input  W each  unsigned vertex coordinates.
REQ-008 out_valid  output  1  out_x/out_y hold an inside pixel.
REQ-009 out_ready  input  1  consumer accepts the pixel.
REQ-010 out_x, out_y  output  W each  pixel coordinate.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of each triangle.
REQ-013 pix_count  output  2W  inside pixels emitted for the current/last triangle.

Function
REQ-014 FSM states IDLE, SETUP, SCAN, DONE; in_ready = 1 only in IDLE.
REQ-015 IDLE: on in_valid && in_ready, register all six coordinates and go to SETUP; otherwise stay.
REQ-016 SETUP (exactly one cycle): register bbox xmin/xmax/ymin/ymax as min/max of the vertex coordinates; compute area = E12(p3).
REQ-017 SETUP: area == 0 (collinear or coincident vertices) -> DONE with no pixel output; else x=xmin, y=ymin -> SCAN.
REQ-018 Edge function Eab(x,y) = (x - bx)*(ay - by) - (ax - bx)*(y - by); differences signed W+1 bits, products signed 2W+2, result signed 2W+3; no truncation.
REQ-019 Evaluated edges E12, E23, E31 on current (x,y); inside when all three >= 0 or all <= 0 (INCLUSIVE=1), or all > 0 or all < 0 (INCLUSIVE=0); either winding is accepted.
REQ-020 SCAN: out_valid = inside(x,y), derived from registered x,y and vertices only; out_x = x, out_y = y.
REQ-021 SCAN advance when !inside or out_ready; while out_valid && !out_ready, x, y, out_x, out_y held stable.
REQ-022 Raster order: x++ until xmax, then x = xmin, y++; advancing from (xmax, ymax) goes to DONE.
REQ-023 One bbox pixel per cycle with out_ready held high; SCAN lasts (xmax-xmin+1)*(ymax-ymin+1) cycles plus stall cycles.
REQ-024 DONE: done = 1 for one cycle, out_valid = 0, next state IDLE.
REQ-025 Vertices equal to 0 or 2^W-1 handled without wrap; x/y counters are W+1 bits internally.

Reset
REQ-026 rst_n low at any time, including mid-SCAN, forces IDLE immediately; in-flight triangle discarded with no done pulse.
REQ-027 Reset values: in_ready=1 (after state=IDLE), out_valid=0, out_x=0, out_y=0, busy=0, done=0, pix_count=0, all registered coordinates 0.

Configuration
REQ-028 Macro TRI_COUNT_EN defined: pix_count cleared on triangle acceptance, incremented on each out_valid && out_ready, held after DONE until next acceptance.
REQ-029 Macro TRI_COUNT_EN undefined: pix_count port present, driven constant 0, no counter logic.

Verification
REQ-030 W=12, INCLUSIVE=1, out_ready=1, triangle (0,0),(2,0),(0,2) -> outputs (0,0),(1,0),(2,0),(0,1),(1,1),(0,2) in that order, done 9 SCAN cycles after entry, pix_count=6 (TRI_COUNT_EN).
REQ-031 Same triangle, vertices ordered (0,0),(0,2),(2,0) -> identical 6-pixel sequence; with INCLUSIVE=0 -> zero outputs, done after 9 SCAN cycles.
REQ-032 Collinear (0,0),(1,1),(2,2) accepted at cycle T -> SETUP at T+1, done=1 at T+2, no out_valid.
REQ-033 Backpressure: out_ready=0 for 3 cycles while (1,0) presented -> out_valid, out_x=1, out_y=0 held 4 cycles; sequence unchanged afterward.
REQ-034 rst_n pulsed low during SCAN of triangle (13,13),(32,10),(16,30) -> next cycle busy=0, out_valid=0, in_ready=1, no done; following triangle processed normally.

Source files
------------

// File: rtl/tri_raster.sv
// Triangle rasteriser: scans the vertex bounding box in raster order and emits inside pixels.
// Optional pixel counter on pix_count enabled by defining TRI_COUNT_EN.
module tri_raster #(
    parameter int W         = 12,
    parameter int INCLUSIVE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   p1x,
    input  logic [W-1:0]   p1y,
    input  logic [W-1:0]   p2x,
    input  logic [W-1:0]   p2y,
    input  logic [W-1:0]   p3x,
    input  logic [W-1:0]   p3y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_x,
    output logic [W-1:0]   out_y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] pix_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0] r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
    logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [W:0]   r_x, r_y;
    logic         r_in_ready, r_busy, r_done;

    logic [2*W+2:0] w_area, w_e12, w_e23, w_e31;
    logic [2:0]     w_neg, w_zero, w_pos;
    logic           w_inside, w_scan, w_adv, w_last, w_x_end, w_accept;
    logic [W-1:0]   w_xmin, w_xmax, w_ymin, w_ymax;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m    = (a < b) ? a : b;
        min3 = (m < c) ? m : c;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m    = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

    // (px-bx)*(ay-by) - (ax-bx)*(py-by) in full two's-complement precision
    function automatic logic [2*W+2:0] edge_fn(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                               input logic [W-1:0] bx, input logic [W-1:0] by,
                                               input logic [W-1:0] px, input logic [W-1:0] py);
        logic [W:0]     d_px, d_aby, d_abx, d_py;
        logic [2*W+1:0] m_a, m_b;
        d_px    = {1'b0, px} - {1'b0, bx};
        d_aby   = {1'b0, ay} - {1'b0, by};
        d_abx   = {1'b0, ax} - {1'b0, bx};
        d_py    = {1'b0, py} - {1'b0, by};
        m_a     = {{(W+1){d_px[W]}}, d_px} * {{(W+1){d_aby[W]}}, d_aby};
        m_b     = {{(W+1){d_abx[W]}}, d_abx} * {{(W+1){d_py[W]}}, d_py};
        edge_fn = {m_a[2*W+1], m_a} - {m_b[2*W+1], m_b};
    endfunction

    assign w_area = edge_fn(r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y);
    assign w_e12  = edge_fn(r_p1x, r_p1y, r_p2x, r_p2y, r_x[W-1:0], r_y[W-1:0]);
    assign w_e23  = edge_fn(r_p2x, r_p2y, r_p3x, r_p3y, r_x[W-1:0], r_y[W-1:0]);
    assign w_e31  = edge_fn(r_p3x, r_p3y, r_p1x, r_p1y, r_x[W-1:0], r_y[W-1:0]);

    assign w_neg  = {w_e31[2*W+2], w_e23[2*W+2], w_e12[2*W+2]};
    assign w_zero = {~|w_e31, ~|w_e23, ~|w_e12};
    assign w_pos  = ~w_neg & ~w_zero;

    // Either winding is accepted, so the test is symmetric in sign
    assign w_inside = (INCLUSIVE != 0) ? ((~|w_neg) | (&(w_neg | w_zero)))
                                       : ((&w_pos) | (&w_neg));

    assign w_xmin   = min3(r_p1x, r_p2x, r_p3x);
    assign w_xmax   = max3(r_p1x, r_p2x, r_p3x);
    assign w_ymin   = min3(r_p1y, r_p2y, r_p3y);
    assign w_ymax   = max3(r_p1y, r_p2y, r_p3y);

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_scan   = (r_state == SCAN);
    assign w_adv    = w_scan && (!w_inside || out_ready);
    assign w_x_end  = (r_x == {1'b0, r_xmax});
    assign w_last   = w_x_end && (r_y == {1'b0, r_ymax});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? SETUP : IDLE;
            SETUP:   w_next = (~|w_area) ? DONE : SCAN;
            SCAN:    w_next = (w_adv && w_last) ? DONE : SCAN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_next == IDLE);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
        end
    end

    // Vertex capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1x <= {W{1'b0}};
            r_p1y <= {W{1'b0}};
            r_p2x <= {W{1'b0}};
            r_p2y <= {W{1'b0}};
            r_p3x <= {W{1'b0}};
            r_p3y <= {W{1'b0}};
        end else if (w_accept) begin
            r_p1x <= p1x;
            r_p1y <= p1y;
            r_p2x <= p2x;
            r_p2y <= p2y;
            r_p3x <= p3x;
            r_p3y <= p3y;
        end
    end

    // Bounding box setup and raster walk; a stalled inside pixel holds x/y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xmin <= {W{1'b0}};
            r_xmax <= {W{1'b0}};
            r_ymin <= {W{1'b0}};
            r_ymax <= {W{1'b0}};
            r_x    <= {(W+1){1'b0}};
            r_y    <= {(W+1){1'b0}};
        end else if (r_state == SETUP) begin
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymin <= w_ymin;
            r_ymax <= w_ymax;
            r_x    <= {1'b0, w_xmin};
            r_y    <= {1'b0, w_ymin};
        end else if (w_adv && !w_last) begin
            if (w_x_end) begin
                r_x <= {1'b0, r_xmin};
                r_y <= r_y + {{W{1'b0}}, 1'b1};
            end else begin
                r_x <= r_x + {{W{1'b0}}, 1'b1};
            end
        end
    end

`ifdef TRI_COUNT_EN
    logic [2*W-1:0] r_pix_count;

    // Inside pixels handed over for the current triangle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_count <= {(2*W){1'b0}};
        end else if (w_accept) begin
            r_pix_count <= {(2*W){1'b0}};
        end else if (out_valid && out_ready) begin
            r_pix_count <= r_pix_count + {{(2*W-1){1'b0}}, 1'b1};
        end
    end

    assign pix_count = r_pix_count;
`else
    assign pix_count = {(2*W){1'b0}};
`endif

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = w_scan && w_inside;
    assign out_x     = r_x[W-1:0];
    assign out_y     = r_y[W-1:0];

endmodule

// File: tb/tb_tri_raster.sv
// Bench for tri_raster: inclusive and exclusive instances share stimulus and are checked each
// cycle against a bounding-box walking model, plus hand-computed expectations.
module tb_tri_raster;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [W-1:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;

    logic [1:0]     o_rdy, o_val, o_busy, o_done;
    logic [W-1:0]   o_x [2];
    logic [W-1:0]   o_y [2];
    logic [2*W-1:0] o_cnt [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tri_raster #(.W(W), .INCLUSIVE(1)) u_inc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .out_valid(o_val[0]), .out_ready(out_ready), .out_x(o_x[0]), .out_y(o_y[0]),
        .busy(o_busy[0]), .done(o_done[0]), .pix_count(o_cnt[0])
    );

    tri_raster #(.W(W), .INCLUSIVE(0)) u_exc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .out_valid(o_val[1]), .out_ready(out_ready), .out_x(o_x[1]), .out_y(o_y[1]),
        .busy(o_busy[1]), .done(o_done[1]), .pix_count(o_cnt[1])
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     mph [2];      // 0 idle, 1 setup, 2 scanning, 3 finished
    int     mx [2], my [2];
    longint mcnt [2];
    int     mv [2][6];
    int     qi[$], qx[$];
    int     hold10 = 0;

    function automatic longint ef(int ax, int ay, int bx, int by, int px, int py);
        return (longint'(px) - bx) * (longint'(ay) - by) - (longint'(ax) - bx) * (longint'(py) - by);
    endfunction

    function automatic bit m_inside(int m, int px, int py);
        longint e0, e1, e2;
        e0 = ef(mv[m][0], mv[m][1], mv[m][2], mv[m][3], px, py);
        e1 = ef(mv[m][2], mv[m][3], mv[m][4], mv[m][5], px, py);
        e2 = ef(mv[m][4], mv[m][5], mv[m][0], mv[m][1], px, py);
        if (m == 0) return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
        return (e0 > 0 && e1 > 0 && e2 > 0) || (e0 < 0 && e1 < 0 && e2 < 0);
    endfunction

    function automatic int mn(int a, int b, int c);
        int r;
        r = (a < b) ? a : b;
        return (r < c) ? r : c;
    endfunction

    function automatic int mxf(int a, int b, int c);
        int r;
        r = (a > b) ? a : b;
        return (r > c) ? r : c;
    endfunction

    // Compare every cycle, then advance the model with the inputs the next edge will sample
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                mph[m]  = 0;
                mcnt[m] = 0;
                chk($sformatf("rst_in_ready[%0d]", m), o_rdy[m], 1);
                chk($sformatf("rst_out_valid[%0d]", m), o_val[m], 0);
                chk($sformatf("rst_busy[%0d]", m), o_busy[m], 0);
                chk($sformatf("rst_done[%0d]", m), o_done[m], 0);
                chk($sformatf("rst_out_x[%0d]", m), o_x[m], 0);
                chk($sformatf("rst_out_y[%0d]", m), o_y[m], 0);
                chk($sformatf("rst_pix_count[%0d]", m), o_cnt[m], 0);
            end else begin
                bit ins;
                int xmin, xmax, ymin, ymax;
                ins  = (mph[m] == 2) && m_inside(m, mx[m], my[m]);
                xmin = mn(mv[m][0], mv[m][2], mv[m][4]);
                xmax = mxf(mv[m][0], mv[m][2], mv[m][4]);
                ymin = mn(mv[m][1], mv[m][3], mv[m][5]);
                ymax = mxf(mv[m][1], mv[m][3], mv[m][5]);
                chk($sformatf("in_ready[%0d]", m), o_rdy[m], mph[m] == 0);
                chk($sformatf("busy[%0d]", m), o_busy[m], mph[m] != 0);
                chk($sformatf("done[%0d]", m), o_done[m], mph[m] == 3);
                chk($sformatf("out_valid[%0d]", m), o_val[m], ins);
`ifdef TRI_COUNT_EN
                chk($sformatf("pix_count[%0d]", m), o_cnt[m], mcnt[m]);
`else
                chk($sformatf("pix_count[%0d]", m), o_cnt[m], 0);
`endif
                if (mph[m] == 2) begin
                    chk($sformatf("out_x[%0d]", m), o_x[m], mx[m]);
                    chk($sformatf("out_y[%0d]", m), o_y[m], my[m]);
                end
                if (o_val[m] && out_ready) begin
                    if (m == 0) qi.push_back(int'(o_x[m]) * 65536 + int'(o_y[m]));
                    else        qx.push_back(int'(o_x[m]) * 65536 + int'(o_y[m]));
                end
                if (m == 0 && o_val[m] && o_x[m] == 1 && o_y[m] == 0) hold10++;
                case (mph[m])
                    0: if (in_valid) begin
                        mv[m] = '{int'(p1x), int'(p1y), int'(p2x), int'(p2y), int'(p3x), int'(p3y)};
                        mcnt[m] = 0;
                        mph[m]  = 1;
                    end
                    1: if (ef(mv[m][0], mv[m][1], mv[m][2], mv[m][3], mv[m][4], mv[m][5]) == 0) begin
                        mph[m] = 3;
                    end else begin
                        mx[m] = xmin;
                        my[m] = ymin;
                        mph[m] = 2;
                    end
                    2: begin
                        if (ins && out_ready) mcnt[m]++;
                        if (!ins || out_ready) begin
                            if (mx[m] == xmax && my[m] == ymax) mph[m] = 3;
                            else if (mx[m] == xmax) begin mx[m] = xmin; my[m]++; end
                            else mx[m]++;
                        end
                    end
                    default: mph[m] = 0;
                endcase
            end
        end
    end

    // Stimulus-side backpressure: stall three cycles on the first presentation of (1,0)
    logic stall_arm = 1'b0;
    int   stall_used = 0;
    always @(posedge clk) begin
        #1;
        if (stall_arm && o_val[0] && o_x[0] == 1 && o_y[0] == 0 && stall_used < 3) begin
            out_ready = 1'b0;
            stall_used++;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic offer(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (o_rdy == 2'b11) begin ok = 1; break; end
        end
        chk("idle_wait", ok, 1);
        @(posedge clk); #1;
        p1x = ax[W-1:0]; p1y = ay[W-1:0]; p2x = bx[W-1:0];
        p2y = by[W-1:0]; p3x = cx[W-1:0]; p3y = cy[W-1:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, output int lat_i, output int lat_x);
        offer(ax, ay, bx, by, cx, cy);
        lat_i = -1;
        lat_x = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (o_done[0] && lat_i < 0) lat_i = k;
            if (o_done[1] && lat_x < 0) lat_x = k;
            if (lat_i >= 0 && lat_x >= 0) break;
        end
        if (lat_i < 0 || lat_x < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_list(input string nm, input int s);
        int exp_px [6] = '{0, 65536, 131072, 1, 65537, 2};
        chk({nm, "_npix"}, qi.size() - s, 6);
        for (int j = 0; j < 6 && s + j < qi.size(); j++) chk({nm, "_pix"}, qi[s + j], exp_px[j]);
    endtask

    initial begin
        int li, lx, si, sx, h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // right triangle, counter-clockwise
        si = qi.size(); sx = qx.size();
        run_tri(0, 0, 2, 0, 0, 2, li, lx);
        chk("req030_lat_incl", li, 11);
        chk("req030_lat_excl", lx, 11);
        chk_list("req030", si);
        chk("req030_excl_npix", qx.size() - sx, 0);
`ifdef TRI_COUNT_EN
        chk("req030_pix_count", o_cnt[0], 6);
`endif

        // same triangle, other winding
        si = qi.size(); sx = qx.size();
        run_tri(0, 0, 0, 2, 2, 0, li, lx);
        chk("req031_lat_incl", li, 11);
        chk("req031_lat_excl", lx, 11);
        chk_list("req031", si);
        chk("req031_excl_npix", qx.size() - sx, 0);

        // collinear: setup then done
        si = qi.size(); sx = qx.size();
        run_tri(0, 0, 1, 1, 2, 2, li, lx);
        chk("req032_lat_incl", li, 2);
        chk("req032_lat_excl", lx, 2);
        chk("req032_npix", qi.size() - si + qx.size() - sx, 0);

        // backpressure on (1,0)
        stall_arm = 1'b1;
        si = qi.size(); h0 = hold10;
        run_tri(0, 0, 2, 0, 0, 2, li, lx);
        chk("req033_lat_incl", li, 14);
        chk("req033_lat_excl", lx, 11);
        chk("req033_hold", hold10 - h0, 4);
        chk_list("req033", si);

        // coordinates at the top of the range
        si = qi.size(); sx = qx.size();
        run_tri(4093, 4095, 4095, 4093, 4095, 4095, li, lx);
        chk("edge_lat_incl", li, 11);
        chk("edge_npix_incl", qi.size() - si, 6);
        chk("edge_npix_excl", qx.size() - sx, 0);

        // reset in the middle of a scan
        offer(13, 13, 32, 10, 16, 30);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("req034_busy", o_busy[0], 0);
        chk("req034_out_valid", o_val[0], 0);
        chk("req034_in_ready", o_rdy[0], 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("req034_no_done", o_done, 0);
        end

        // following triangle behaves normally
        run_tri(5, 1, 1, 4, 7, 6, li, lx);
        chk("post_rst_lat_incl", li, 44);
        chk("post_rst_lat_excl", lx, 44);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
